// File: rtl/d_p_ram_if.sv
// Bus bundle for d_p_ram: one write port, one read port, combinational read data.
interface d_p_ram_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32
);
  logic                  write_en;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [DATA_WIDTH-1:0] input_data;
  logic [DATA_WIDTH-1:0] output_data;

  modport master (
    output write_en, write_addr, read_addr, input_data,
    input  output_data
  );

  modport slave (
    input  write_en, write_addr, read_addr, input_data,
    output output_data
  );
endinterface

// File: rtl/d_p_ram.sv
// Simple dual-port RAM: synchronous write, zero-latency read, whole-array sync clear on rst.
// Optional macro D_P_RAM_WR_BYPASS_EN forwards same-address write data to the read port.
module d_p_ram #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input logic       clk,
  input logic       rst,
  d_p_ram_if.slave  bus
);

  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data;

  // Addresses at or beyond DEPTH never touch storage: writes drop, reads give zero.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return {1'b0, addr} < DEPTH_LIM;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bus.write_en && in_range(bus.write_addr)) begin
      mem[bus.write_addr] <= bus.input_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if (in_range(bus.read_addr)) rd_data = mem[bus.read_addr];
`ifdef D_P_RAM_WR_BYPASS_EN
    if (bus.write_en && !rst && in_range(bus.write_addr) &&
        (bus.read_addr == bus.write_addr))
      rd_data = bus.input_data;
`endif
  end

  assign bus.output_data = rd_data;

endmodule

// File: tb/tb_d_p_ram.sv
// Randomized plus directed bench for d_p_ram (full-depth and DEPTH=6 instances) against an array model.
module tb_d_p_ram;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  logic [31:0] ref8 [8];
  logic [31:0] ref6 [8];

  d_p_ram_if #(.ADDR_WIDTH(3), .DATA_WIDTH(32)) bus8 ();
  d_p_ram_if #(.ADDR_WIDTH(3), .DATA_WIDTH(32)) bus6 ();

  d_p_ram #(.ADDR_WIDTH(3), .DATA_WIDTH(32), .DEPTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  d_p_ram #(.ADDR_WIDTH(3), .DATA_WIDTH(32), .DEPTH(6)) dut6 (
    .clk (clk),
    .rst (rst),
    .bus (bus6)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected read value for a RAM of the given depth holding words in m.
  function automatic logic [31:0] exp_rd(input int depth, input logic [31:0] m [8],
                                         input bit r, input bit we, input int wa,
                                         input int ra, input logic [31:0] d);
    logic [31:0] v;
    v = (ra < depth) ? m[ra] : 32'h0;
`ifdef D_P_RAM_WR_BYPASS_EN
    if (we && !r && (wa < depth) && (ra == wa)) v = d;
`endif
    return v;
  endfunction

  task automatic cycle(input bit r, input bit we, input int wa, input int ra,
                       input logic [31:0] d);
    rst             = r;
    bus8.write_en   = we;
    bus8.write_addr = 3'(wa);
    bus8.read_addr  = 3'(ra);
    bus8.input_data = d;
    bus6.write_en   = we;
    bus6.write_addr = 3'(wa);
    bus6.read_addr  = 3'(ra);
    bus6.input_data = d;
    #4;
    if (chk_en) begin
      check($sformatf("rd8 a%0d", ra), bus8.output_data, exp_rd(8, ref8, r, we, wa, ra, d));
      check($sformatf("rd6 a%0d", ra), bus6.output_data, exp_rd(6, ref6, r, we, wa, ra, d));
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 8; i++) begin
        ref8[i] = 32'h0;
        ref6[i] = 32'h0;
      end
    end else if (we) begin
      ref8[wa] = d;
      if (wa < 6) ref6[wa] = d;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus8.write_en = 1'b0; bus8.write_addr = '0; bus8.read_addr = '0; bus8.input_data = '0;
    bus6.write_en = 1'b0; bus6.write_addr = '0; bus6.read_addr = '0; bus6.input_data = '0;
    @(posedge clk);
    #1;
    cycle(1'b1, 1'b0, 0, 0, 32'h0);
    chk_en = 1'b1;

    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 0, i, 32'h0);

    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, i, (i + 4) % 8, 32'hA0 + 32'(i));
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 0, i, 32'h0);

    cycle(1'b0, 1'b1, 5, 2, 32'h1234);
    cycle(1'b0, 1'b0, 0, 5, 32'h0);

    cycle(1'b0, 1'b1, 3, 3, 32'h11);
    cycle(1'b0, 1'b1, 3, 3, 32'h22);
    cycle(1'b0, 1'b0, 0, 3, 32'h0);

    cycle(1'b1, 1'b1, 4, 4, 32'hFF);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 0, i, 32'h0);

    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, i, 7, 32'hC0 + 32'(i));
    cycle(1'b0, 1'b1, 6, 6, 32'h55);
    cycle(1'b0, 1'b1, 7, 6, 32'h77);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 0, i, 32'h0);

    for (int n = 0; n < 400; n++) begin
      int wa, ra;
      wa = int'($urandom_range(7));
      ra = ($urandom_range(3) == 0) ? wa : int'($urandom_range(7));
      cycle(($urandom_range(39) == 0), $urandom_range(1) == 1, wa, ra, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/d_p_ram.md
D_P_RAM -- requirements
Module: d_p_ram

Interface
REQ-001 Parameter ADDR_WIDTH, default 3, address bus width in bits.
REQ-002 Parameter DATA_WIDTH, default 32, word width in bits.
REQ-003 Parameter DEPTH, default 1<<ADDR_WIDTH, number of storage words; legal range 1..2^ADDR_WIDTH.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 write_en  input  1  write strobe, sampled at rising clk.
REQ-007 write_addr  input  ADDR_WIDTH  write port word address.
REQ-008 read_addr  input  ADDR_WIDTH  read port word address.
REQ-009 input_data  input  DATA_WIDTH  write data.
REQ-010 output_data  output  DATA_WIDTH  read data.

Function
REQ-011 Storage SHALL be DEPTH words of DATA_WIDTH bits, with write and read ports fully independent (simple dual-port: 1 write, 1 read).
REQ-012 Write: at rising clk with rst=0 and write_en=1 and write_addr<DEPTH, mem[write_addr] SHALL take input_data; visible on the read port from the following cycle.
REQ-013 write_en=0 SHALL leave every word unchanged.
REQ-014 Writes with write_addr>=DEPTH SHALL be ignored (no aliasing, no wrap).
REQ-015 Read: output_data SHALL be combinational, zero-latency: output_data = mem[read_addr] in the same cycle read_addr changes.
REQ-016 Reads with read_addr>=DEPTH SHALL return all zeros.
REQ-017 Read and write to different addresses in the same cycle SHALL not interact.
REQ-018 Same-address read/write collision (write_en=1, read_addr==write_addr) without bypass: output_data SHALL show the old stored word until the clock edge, the new word after it.
REQ-019 A write in the same cycle as rst=1 SHALL be discarded.
REQ-020 The read path SHALL have no dependence on write_en except as stated in REQ-027.

Reset
REQ-021 At rising clk with rst=1, every word SHALL be cleared to zero in that single cycle.
REQ-022 After reset, output_data SHALL be 0 for every read_addr until a word is written.
REQ-023 rst asserted mid-operation SHALL override any write and clear all contents; no partial state survives.
REQ-024 Before the first reset, contents and output_data are undefined (X allowed in simulation).

Configuration
REQ-025 Macro D_P_RAM_WR_BYPASS_EN selects write-to-read forwarding.
REQ-026 Without D_P_RAM_WR_BYPASS_EN: collision behaviour per REQ-018.
REQ-027 With D_P_RAM_WR_BYPASS_EN: when write_en=1, rst=0, write_addr<DEPTH and read_addr==write_addr, output_data SHALL equal input_data combinationally in that same cycle; all other behaviour unchanged.

Verification
REQ-028 Reset then sweep read_addr 0..7 -> output_data=0 for every address.
REQ-029 Write 0xA0+i to addr i for i=0..7, then read 0..7 -> output_data=0xA0+i, each read valid in the same cycle read_addr is applied.
REQ-030 Write 0x1234 to addr 5 while reading addr 2 (holding 0xA2) -> output_data stays 0xA2; next cycle read addr 5 -> 0x1234.
REQ-031 Addr 3 holds 0x11; write 0x22 to addr 3 while read_addr=3 -> output_data 0x11 before the edge, 0x22 after (macro off); 0x22 during the write cycle (macro on).
REQ-032 rst=1 together with write_en=1, addr 4, data 0xFF -> after the edge, all addresses including 4 read 0.
REQ-033 DEPTH=6, ADDR_WIDTH=3: write 0x55 to addr 6 -> read addr 6 returns 0, addrs 0..5 unchanged.
